// File: rtl/matmul_if.sv
// Byte-wide cs/rw/comdat host bus shared by the lab accelerator peripherals.
// The host side drives the strobe and write byte; the engine returns data_out.
interface matmul_if;
   logic       cs;
   logic       rw;
   logic       comdat;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (
      output cs, rw, comdat, data_in,
      input  data_out
   );

   modport slave (
      input  cs, rw, comdat, data_in,
      output data_out
   );
endinterface

// File: rtl/matmul_engine.sv
// Sequential N x N unsigned matrix multiplier with LANES parallel MACs.
// Host loads A/B through an auto-incrementing pointer, starts, polls, reads C.
module matmul_engine #(
   parameter int N     = 8,
   parameter int LANES = 4
) (
   input logic      clk,
   input logic      rst_n,
   matmul_if.slave  bus
);
   localparam int NN   = N * N;
   localparam int AW   = $clog2(2 * NN);
   localparam int ACCW = 16 + $clog2(N);
   localparam int GPR  = N / LANES;
   localparam int NG   = NN / LANES;
   localparam int KW   = $clog2(N);
   localparam int GW   = $clog2(NG);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_WB
   } state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [GW-1:0]   g_q, g_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            done_q, done_d;
   logic            sat_q, sat_d;
   logic [7:0]      dout_q, dout_d;
   logic [ACCW-1:0] acc_q [LANES];
   logic [ACCW-1:0] acc_d [LANES];
   logic [15:0]     prod [LANES];
   logic [7:0]      wb_val [LANES];
   logic [7:0]      a_mem [NN];
   logic [7:0]      b_mem [NN];
   logic [7:0]      c_q [NN];
   logic            wb_en, st_en;
   logic            wr_dat, rd_dat, wr_cmd, rd_st;
   int              ri, cj0;

   assign wr_dat = bus.cs & ~bus.rw & ~bus.comdat;
   assign rd_dat = bus.cs &  bus.rw & ~bus.comdat;
   assign wr_cmd = bus.cs & ~bus.rw &  bus.comdat;
   assign rd_st  = bus.cs &  bus.rw &  bus.comdat;
   assign bus.data_out = dout_q;

   // Current group: one row, LANES adjacent columns.
   always_comb begin
      ri  = int'(g_q) / GPR;
      cj0 = (int'(g_q) % GPR) * LANES;
      for (int l = 0; l < LANES; l++) begin
         prod[l] = 16'(a_mem[ri*N + int'(k_q)])
                 * 16'(b_mem[int'(k_q)*N + cj0 + l]);
         if (sat_q && |acc_q[l][ACCW-1:8]) begin
            wb_val[l] = 8'hFF;
         end else begin
            wb_val[l] = acc_q[l][7:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      done_d  = done_q;
      sat_d   = sat_q;
      dout_d  = dout_q;
      wb_en   = 1'b0;
      st_en   = 1'b0;
      for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l];

      unique case (state_q)
         S_MAC: begin
            for (int l = 0; l < LANES; l++) begin
               acc_d[l] = (k_q == '0 ? '0 : acc_q[l])
                        + ACCW'(prod[l]);
            end
            k_d = k_q + 1'b1;
            if (k_q == KW'(N - 1)) state_d = S_WB;
         end
         S_WB: begin
            wb_en = 1'b1;
            k_d   = '0;
            if (g_q == GW'(NG - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               g_d     = '0;
            end else begin
               state_d = S_MAC;
               g_d     = g_q + 1'b1;
            end
         end
         default: ;
      endcase

      if (wr_dat) begin
         ptr_d = ptr_q + 1'b1;
         st_en = (state_q == S_IDLE);
      end
      if (rd_dat) begin
         ptr_d  = ptr_q + 1'b1;
         dout_d = ptr_q[AW-1] ? 8'h00 : c_q[ptr_q[AW-2:0]];
      end
      if (rd_st) begin
         dout_d = {state_q != S_IDLE, done_q, sat_q, 5'b0};
      end

      // CLEAR overrides a same-cycle write-back.
      if (wr_cmd) begin
         unique case (1'b1)
            !bus.data_in[7]: begin
               ptr_d = bus.data_in[AW-1:0];
            end
            bus.data_in[7:6] == 2'b10: begin
               if (state_q == S_IDLE) begin
                  state_d = S_MAC;
                  k_d     = '0;
                  g_d     = '0;
                  sat_d   = bus.data_in[0];
                  done_d  = 1'b0;
               end
            end
            bus.data_in[7:6] == 2'b11: begin
               state_d = S_IDLE;
               k_d     = '0;
               g_d     = '0;
               done_d  = 1'b0;
               ptr_d   = '0;
               wb_en   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         g_q     <= '0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         sat_q   <= 1'b0;
         dout_q  <= 8'h00;
         for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         sat_q   <= sat_d;
         dout_q  <= dout_d;
         for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < NN; e++) c_q[e] <= 8'h00;
      end else if (wb_en) begin
         for (int l = 0; l < LANES; l++) begin
            c_q[ri*N + cj0 + l] <= wb_val[l];
         end
      end
   end

   // Operand storage needs no reset; contents are undefined until loaded.
   always_ff @(posedge clk) begin
      if (st_en) begin
         if (ptr_q[AW-1]) b_mem[ptr_q[AW-2:0]] <= bus.data_in;
         else             a_mem[ptr_q[AW-2:0]] <= bus.data_in;
      end
   end
endmodule

// File: tb/tb_matmul_engine.sv
// Randomized bench for matmul_engine against a plain-arithmetic matrix model.
// Drives an N=8/LANES=4 build and an N=2/LANES=2 build over the byte bus.
module tb_matmul_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matmul_if b8 ();
   matmul_if b2 ();

   matmul_engine #(.N(8), .LANES(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8)
   );

   matmul_engine #(.N(2), .LANES(2)) u_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2)
   );

   int n_pass = 0;
   int n_chk  = 0;
   int sel    = 0;
   int n      = 8;
   int lanes  = 4;
   int ma [64];
   int mb [64];
   int mc [64];
   int mx [64];
   logic [7:0] q;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic acc(input logic r, input logic c, input logic [7:0] d,
                      output logic [7:0] o);
      @(negedge clk);
      if (sel == 0) begin
         b8.cs = 1'b1; b8.rw = r; b8.comdat = c; b8.data_in = d;
      end else begin
         b2.cs = 1'b1; b2.rw = r; b2.comdat = c; b2.data_in = d;
      end
      @(posedge clk);
      #1;
      b8.cs = 1'b0;
      b2.cs = 1'b0;
      o = (sel == 0) ? b8.data_out : b2.data_out;
   endtask

   task automatic cmd(input logic [7:0] d);
      logic [7:0] o;
      acc(1'b0, 1'b1, d, o);
   endtask

   task automatic wr(input logic [7:0] d);
      logic [7:0] o;
      acc(1'b0, 1'b0, d, o);
   endtask

   task automatic rdd(output logic [7:0] o);
      acc(1'b1, 1'b0, 8'h00, o);
   endtask

   task automatic st(output logic [7:0] o);
      acc(1'b1, 1'b1, 8'h00, o);
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
   endtask

   function automatic int refc(int i, int j, bit s);
      int sum = 0;
      for (int k = 0; k < n; k++) sum += ma[i*n+k] * mb[k*n+j];
      return s ? (sum > 255 ? 255 : sum) : sum % 256;
   endfunction

   task automatic load();
      cmd(8'h00);
      for (int e = 0; e < 2*n*n; e++) begin
         wr(8'(e < n*n ? ma[e] : mb[e - n*n]));
      end
   endtask

   task automatic fill_rand(input int mxa, input int mxb);
      for (int e = 0; e < n*n; e++) begin
         ma[e] = $urandom_range(0, mxa);
         mb[e] = $urandom_range(0, mxb);
      end
   endtask

   // Polls status until idle; pre = bus cycles already spent after START.
   task automatic wait_done(input bit s, input string tag, input int pre);
      logic [7:0] o;
      int busy_n = pre;
      do begin
         st(o);
         if (o[7]) busy_n++;
      end while (o[7] && busy_n < 2000);
      check({tag, "_lat"}, busy_n, (n*n/lanes)*(n+1));
      check({tag, "_stat"}, o, {1'b0, 1'b1, s, 5'b0});
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) mc[i*n+j] = refc(i, j, s);
   endtask

   task automatic run(input bit s, input string tag);
      cmd(s ? 8'h81 : 8'h80);
      wait_done(s, tag, 0);
   endtask

   task automatic readc(input string tag, input bit setptr);
      logic [7:0] o;
      if (setptr) cmd(8'h00);
      for (int e = 0; e < n*n; e++) begin
         rdd(o);
         check($sformatf("%s_c%0d", tag, e), o, mc[e]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      b8.cs = 0; b8.rw = 0; b8.comdat = 0; b8.data_in = 0;
      b2.cs = 0; b2.rw = 0; b2.comdat = 0; b2.data_in = 0;
      for (int e = 0; e < 64; e++) mc[e] = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      st(q);
      check("rst_stat", q, 8'h00);
      rdd(q);
      check("rst_c0", q, 8'h00);

      for (int e = 0; e < 64; e++) begin
         ma[e] = (e / 8 == e % 8) ? 1 : 0;
         mb[e] = e;
      end
      load();
      run(1'b1, "ident");
      readc("ident", 1'b1);

      for (int e = 0; e < 64; e++) begin
         ma[e] = 16; mb[e] = 16;
      end
      load();
      run(1'b1, "sat");
      readc("sat", 1'b1);
      cmd(8'hC0);
      run(1'b0, "wrap");
      readc("wrap", 1'b1);

      for (int e = 0; e < 64; e++) begin
         ma[e] = 1; mb[e] = 2;
      end
      load();
      run(1'b0, "ones");
      readc("ones", 1'b1);

      fill_rand(15, 15);
      load();
      cmd(8'h7F);
      wr(8'hAA);
      wr(8'hBB);
      mb[63] = 8'hAA;
      ma[0]  = 8'hBB;
      run(1'b0, "ptr");
      readc("ptr", 1'b1);

      fill_rand(7, 31);
      load();
      cmd(8'h00);
      cmd(8'h80);
      wr(8'h55);
      cmd(8'h81);
      wait_done(1'b0, "busy", 2);
      readc("busy", 1'b1);

      // CLEAR sampled 50 edges after START: groups 0..4 have been written back.
      fill_rand(255, 255);
      load();
      for (int e = 0; e < 64; e++) mx[e] = mc[e];
      cmd(8'h80);
      idle(49);
      cmd(8'hC0);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            mc[i*8+j] = (i*2 + j/4 < 5) ? refc(i, j, 1'b0) : mx[i*8+j];
      st(q);
      check("clr_stat", q, 8'h00);
      readc("clr", 1'b0);

      fill_rand(255, 255);
      load();
      cmd(8'h81);
      idle(69);
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int e = 0; e < 64; e++) mc[e] = 0;
      st(q);
      check("arst_stat", q, 8'h00);
      readc("arst", 1'b0);

      for (int r = 0; r < 4; r++) begin
         int pick;
         bit s;
         pick = $urandom_range(0, 2);
         s = 1'($urandom_range(0, 1));
         fill_rand(pick == 0 ? 3 : (pick == 1 ? 15 : 255), 255);
         load();
         run(s, $sformatf("rnd%0d", r));
         readc($sformatf("rnd%0d", r), 1'b1);
      end

      sel = 1; n = 2; lanes = 2;
      ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
      mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
      load();
      run(1'b0, "n2");
      readc("n2", 1'b1);
      fill_rand(255, 255);
      load();
      run(1'b1, "n2sat");
      readc("n2sat", 1'b1);
      rdd(q);
      check("n2_bregion", q, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
